event_packetizer: RTL and testbench

EVENT_PACKETIZER -- requirements
Module: event_packetizer

---
 rtl/event_packetizer_if.sv | 24 ++
 rtl/event_packetizer.sv | 59 +++++
 tb/tb_event_packetizer.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/event_packetizer_if.sv
// event_packetizer_if: event-in / packet-out handshake bundle for event_packetizer.
interface event_packetizer_if #(
  parameter int SIZE = 32,
  parameter int ROW_BITS = 3,
  parameter int COL_BITS = 3
);
  logic evt_valid_i;
  logic evt_ready_o;
  logic [ROW_BITS-1:0] row_i;
  logic [COL_BITS-1:0] col_i;
  logic polarity_i;
  logic [SIZE-1:0] timestamp_i;
  logic pkt_valid_o;
  logic pkt_ready_i;
  logic [SIZE+ROW_BITS+COL_BITS:0] pkt_data_o;
  modport master (
    output evt_valid_i, row_i, col_i, polarity_i, timestamp_i, pkt_ready_i,
    input evt_ready_o, pkt_valid_o, pkt_data_o
  );
  modport slave (
    input evt_valid_i, row_i, col_i, polarity_i, timestamp_i, pkt_ready_i,
    output evt_ready_o, pkt_valid_o, pkt_data_o
  );
endinterface

// File: rtl/event_packetizer.sv
// event_packetizer: first-word-fall-through FIFO packing pixel events as {timestamp, row, col, polarity}.
// Defining EVENT_DROP_COUNT_EN adds drop_cnt_o, a saturating count of events refused while full.
module event_packetizer #(
  parameter int SIZE = 32,
  parameter int ROW_BITS = 3,
  parameter int COL_BITS = 3,
  parameter int DEPTH = 8
) (
  input logic clk_i,
  input logic reset_i,
  event_packetizer_if.slave bus,
  output logic fifo_full_o,
  output logic fifo_empty_o,
  output logic [$clog2(DEPTH):0] fifo_count_o
`ifdef EVENT_DROP_COUNT_EN
  ,
  output logic [15:0] drop_cnt_o
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int W = SIZE + ROW_BITS + COL_BITS + 1;
  localparam logic [AW:0] FULL = DEPTH[AW:0];
  logic [W-1:0] mem [DEPTH];
  logic [W-1:0] last_q;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic push, pop;
  assign fifo_full_o = count == FULL;
  assign fifo_empty_o = count == '0;
  assign fifo_count_o = count;
  assign bus.evt_ready_o = !fifo_full_o;
  assign bus.pkt_valid_o = !fifo_empty_o;
  assign push = bus.evt_valid_i && !fifo_full_o;
  assign pop = bus.pkt_ready_i && !fifo_empty_o;
  // once drained, the slot at rd_ptr is stale, so replay the last popped word instead
  assign bus.pkt_data_o = fifo_empty_o ? last_q : mem[rd_ptr];
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      last_q <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push);
      rd_ptr <= rd_ptr + AW'(pop);
      count <= (push && !pop) ? count + 1'b1 : (pop && !push) ? count - 1'b1 : count;
      if (pop) last_q <= mem[rd_ptr];
    end
  end
  always_ff @(posedge clk_i) begin
    if (push && !reset_i) mem[wr_ptr] <= {bus.timestamp_i, bus.row_i, bus.col_i, bus.polarity_i};
  end
`ifdef EVENT_DROP_COUNT_EN
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) drop_cnt_o <= '0;
    else if (bus.evt_valid_i && fifo_full_o && drop_cnt_o != 16'hFFFF) drop_cnt_o <= drop_cnt_o + 1'b1;
  end
`endif
endmodule

// File: tb/tb_event_packetizer.sv
// tb_event_packetizer: scoreboard bench; stimulus queues accepted packets, a negedge monitor checks the DUT.
module tb_event_packetizer;
  localparam int SIZE = 32, RB = 3, CB = 3, DEPTH = 8, W = SIZE + RB + CB + 1;
  logic clk_i = 0;
  logic reset_i = 1;
  logic fifo_full_o, fifo_empty_o;
  logic [3:0] fifo_count_o;
  logic [W-1:0] sb_q [$];
  logic [W-1:0] last_pop = '0;
  int checks = 0, errors = 0;
  int t = 0;
`ifdef EVENT_DROP_COUNT_EN
  logic [15:0] drop_cnt_o;
  int drops = 0;
`endif
  event_packetizer_if #(.SIZE(SIZE), .ROW_BITS(RB), .COL_BITS(CB)) bus ();
  event_packetizer #(.SIZE(SIZE), .ROW_BITS(RB), .COL_BITS(CB), .DEPTH(DEPTH)) dut (
    .clk_i(clk_i),
    .reset_i(reset_i),
    .bus(bus),
    .fifo_full_o(fifo_full_o),
    .fifo_empty_o(fifo_empty_o),
    .fifo_count_o(fifo_count_o)
`ifdef EVENT_DROP_COUNT_EN
    ,
    .drop_cnt_o(drop_cnt_o)
`endif
  );
  always #5 clk_i = ~clk_i;
  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask
  // monitor: outputs between edges must match the queue of accepted, not yet consumed packets
  always @(negedge clk_i) begin
    if (!reset_i) begin
      chk("count", 64'(fifo_count_o), 64'(sb_q.size()));
      chk("valid", 64'(bus.pkt_valid_o), 64'(sb_q.size() != 0));
      chk("empty", 64'(fifo_empty_o), 64'(sb_q.size() == 0));
      chk("full", 64'(fifo_full_o), 64'(sb_q.size() == DEPTH));
      chk("evt_ready", 64'(bus.evt_ready_o), 64'(sb_q.size() < DEPTH));
`ifdef EVENT_DROP_COUNT_EN
      chk("drop_cnt", 64'(drop_cnt_o), 64'(drops));
`endif
      if (sb_q.size() != 0) begin
        chk("head", 64'(bus.pkt_data_o), 64'(sb_q[0]));
        if (bus.pkt_ready_i) last_pop = sb_q.pop_front();
      end else chk("hold", 64'(bus.pkt_data_o), 64'(last_pop));
    end
  end
  task automatic step(bit v, bit r, logic [SIZE-1:0] ts, logic [RB-1:0] row, logic [CB-1:0] col, bit pol);
    bit acc;
    @(posedge clk_i);
    #1;
    bus.evt_valid_i = v;
    bus.pkt_ready_i = r;
    bus.timestamp_i = ts;
    bus.row_i = row;
    bus.col_i = col;
    bus.polarity_i = pol;
    acc = v && sb_q.size() < DEPTH;
    @(negedge clk_i);
    #1;
    if (acc) sb_q.push_back({ts, row, col, pol});
`ifdef EVENT_DROP_COUNT_EN
    if (v && !acc && drops < 65535) drops++;
`endif
  endtask
  task automatic check_reset_state();
    chk("rst_valid", 64'(bus.pkt_valid_o), 0);
    chk("rst_empty", 64'(fifo_empty_o), 1);
    chk("rst_full", 64'(fifo_full_o), 0);
    chk("rst_ready", 64'(bus.evt_ready_o), 1);
    chk("rst_count", 64'(fifo_count_o), 0);
    chk("rst_data", 64'(bus.pkt_data_o), 0);
`ifdef EVENT_DROP_COUNT_EN
    chk("rst_drop", 64'(drop_cnt_o), 0);
`endif
  endtask
  initial begin
    bus.evt_valid_i = 0;
    bus.pkt_ready_i = 0;
    bus.timestamp_i = '0;
    bus.row_i = '0;
    bus.col_i = '0;
    bus.polarity_i = 0;
    #1;
    check_reset_state();
    #22;
    reset_i = 0;
    for (int i = 0; i < 3; i++) step(1, 0, 100 + i, 1, 2, 1);
    step(0, 0, 103, 0, 0, 0);
    chk("three_count", 64'(fifo_count_o), 3);
    chk("three_head", 64'(bus.pkt_data_o), 64'({32'd100, 3'd1, 3'd2, 1'b1}));
    for (int i = 0; i < 5; i++) step(1, 0, 103 + i, RB'(i), CB'(7 - i), i[0]);
    step(1, 0, 108, 5, 5, 1);
    step(1, 0, 109, 6, 6, 0);
    step(1, 1, 110, 7, 7, 1);
    step(0, 0, 111, 0, 0, 0);
    chk("full_pop_count", 64'(fifo_count_o), 7);
    for (int i = 0; i < 3; i++) step(0, 1, 111, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(1, 1, 112 + i, RB'(i + 3), CB'(i), !i[0]);
    step(1, 0, 117, 3, 3, 1);
    @(posedge clk_i);
    #3;
    reset_i = 1;
    bus.evt_valid_i = 0;
    bus.pkt_ready_i = 0;
    #1;
    check_reset_state();
    sb_q.delete();
    last_pop = '0;
`ifdef EVENT_DROP_COUNT_EN
    drops = 0;
`endif
    @(negedge clk_i);
    #2;
    reset_i = 0;
    step(1, 0, 5, 2, 6, 0);
    step(0, 0, 6, 0, 0, 0);
    chk("post_rst_count", 64'(fifo_count_o), 1);
    step(0, 1, 6, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      step(1, 1, 10 + 3 * k, RB'(k), CB'(k + 1), k[0]);
      step(0, 1, 10 + 3 * k, 0, 0, 0);
      step(0, 1, 10 + 3 * k, 0, 0, 0);
    end
    t = 20;
    for (int i = 0; i < 400; i++) begin
      bit v, r;
      v = (i < 200) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 2) == 0);
      r = (i < 200) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 3) != 0);
      t += $urandom_range(0, 2);
      step(v, r, t, RB'($urandom), CB'($urandom), 1'($urandom));
    end
    repeat (DEPTH + 2) step(0, 1, t, 0, 0, 0);
    @(negedge clk_i);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
